// File: rtl/uart_tx_channel_gen2.sv
// uart_tx_channel_gen2: baud tick generator, TX FIFO and TX serialiser in one block.
// The runtime baud divisor and FIFO status are always present. Parity generation is built
// only when the macro UART_TX_PARITY_EN is defined. Without it, i_parity_mode is ignored
// and every frame is start + DBIT data bits + stop.
module uart_tx_channel_gen2 #(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int DVSR_BIT = 8,
  parameter int FIFO_W   = 2,
  parameter int OVS      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_wr,
  input  logic [DBIT-1:0]     i_data,
  input  logic [DVSR_BIT-1:0] i_dvsr,
  input  logic [1:0]          i_parity_mode,
  output logic                o_tx,
  output logic                o_full,
  output logic                o_empty,
  output logic [FIFO_W:0]     o_level,
  output logic                o_busy,
  output logic                o_done_tick,
  output logic                o_overflow
);

  localparam int DEPTH  = 2**FIFO_W;
  localparam int MAXT   = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int TCNT_W = $clog2(MAXT + 1);
  localparam int NBIT_W = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [TCNT_W-1:0] OVS_LAST  = TCNT_W'(OVS - 1);
  localparam logic [TCNT_W-1:0] SB_LAST   = TCNT_W'(SB_TICK - 1);
  localparam logic [NBIT_W-1:0] DBIT_LAST = NBIT_W'(DBIT - 1);
  localparam logic [FIFO_W:0]   DEPTH_L   = (FIFO_W+1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // Even parity drives the XOR of the data; odd parity drives its complement.
  function automatic logic f_parity(input logic [DBIT-1:0] data, input logic odd);
    return odd ? ~(^data) : (^data);
  endfunction

  state_t                r_state;
  logic [DVSR_BIT-1:0]   r_bcnt;
  logic [DVSR_BIT-1:0]   w_lim;
  logic                  w_tick;
  logic [DBIT-1:0]       r_mem [DEPTH];
  logic [FIFO_W-1:0]     r_wptr;
  logic [FIFO_W-1:0]     r_rptr;
  logic [FIFO_W:0]       r_level;
  logic [FIFO_W:0]       w_level_nxt;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_overflow;
  logic                  w_push;
  logic                  w_pop;
  logic [DBIT-1:0]       w_head;
  logic [DBIT-1:0]       r_shift;
  logic [TCNT_W-1:0]     r_tcnt;
  logic [NBIT_W-1:0]     r_nbit;
  logic                  w_bit_end;
  logic                  r_tx;
  logic                  r_done;

`ifdef UART_TX_PARITY_EN
  logic                  r_par_en;
  logic                  r_par_bit;
`else
  logic                  w_unused_mode;
  assign w_unused_mode = ^i_parity_mode;
`endif

  // Divisors 0 and 1 both mean one tick per clock.
  assign w_lim  = (i_dvsr > DVSR_BIT'(1)) ? (i_dvsr - DVSR_BIT'(1)) : '0;
  assign w_tick = (r_bcnt == w_lim);

  // Free-running baud counter; an over-range count after a divisor change wraps at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bcnt <= '0;
    end else if (r_bcnt >= w_lim) begin
      r_bcnt <= '0;
    end else begin
      r_bcnt <= r_bcnt + DVSR_BIT'(1);
    end
  end

  // A write while full is rejected even if the serialiser pops in the same cycle.
  assign w_push    = i_wr && !r_full;
  assign w_pop     = (r_state == S_IDLE) && !r_empty;
  assign w_head    = r_mem[r_rptr];
  assign w_bit_end = w_tick && (r_tcnt == OVS_LAST);

  // Next FIFO occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + (FIFO_W+1)'(1);
    end else if (!w_push && w_pop) begin
      w_level_nxt = r_level - (FIFO_W+1)'(1);
    end
  end

  // FIFO storage holds data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // FIFO pointers, registered status flags and the overflow pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + FIFO_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + FIFO_W'(1);
      end
      r_level    <= w_level_nxt;
      r_full     <= (w_level_nxt == DEPTH_L);
      r_empty    <= (w_level_nxt == '0);
      r_overflow <= i_wr && r_full;
    end
  end

  // Shift register: loaded from the FIFO head on pop, shifted right at each data-bit end.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_shift <= w_head;
    end else if ((r_state == S_DATA) && w_bit_end) begin
      r_shift <= r_shift >> 1;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity bit is computed from the byte as it is loaded, using the mode in force then.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_par_bit <= f_parity(w_head, i_parity_mode[1]);
    end
  end
`endif

  // Serialiser FSM; o_tx is registered from the current state, so the line lags state by one clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_tx     <= 1'b1;
      r_done   <= 1'b0;
      r_tcnt   <= '0;
      r_nbit   <= '0;
`ifdef UART_TX_PARITY_EN
      r_par_en <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_tcnt  <= '0;
            r_state <= S_START;
`ifdef UART_TX_PARITY_EN
            r_par_en <= (i_parity_mode == 2'd1) || (i_parity_mode == 2'd2);
`endif
          end
        end
        S_START: begin
          r_tx <= 1'b0;
          if (w_tick) begin
            if (r_tcnt == OVS_LAST) begin
              r_tcnt  <= '0;
              r_nbit  <= '0;
              r_state <= S_DATA;
            end else begin
              r_tcnt <= r_tcnt + TCNT_W'(1);
            end
          end
        end
        S_DATA: begin
          r_tx <= r_shift[0];
          if (w_tick) begin
            if (r_tcnt == OVS_LAST) begin
              r_tcnt <= '0;
              if (r_nbit == DBIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                r_state <= r_par_en ? S_PARITY : S_STOP;
`else
                r_state <= S_STOP;
`endif
              end else begin
                r_nbit <= r_nbit + NBIT_W'(1);
              end
            end else begin
              r_tcnt <= r_tcnt + TCNT_W'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          r_tx <= r_par_bit;
          if (w_tick) begin
            if (r_tcnt == OVS_LAST) begin
              r_tcnt  <= '0;
              r_state <= S_STOP;
            end else begin
              r_tcnt <= r_tcnt + TCNT_W'(1);
            end
          end
        end
`endif
        S_STOP: begin
          r_tx <= 1'b1;
          if (w_tick) begin
            if (r_tcnt == SB_LAST) begin
              r_tcnt  <= '0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_tcnt <= r_tcnt + TCNT_W'(1);
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_tx        = r_tx;
  assign o_full      = r_full;
  assign o_empty     = r_empty;
  assign o_level     = r_level;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done_tick = r_done;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_uart_tx_channel_gen2.sv
// Testbench for uart_tx_channel_gen2: stimulus queues expected frames, a monitor decodes o_tx.
module tb_uart_tx_channel_gen2;

  localparam int DBIT = 8;
  localparam int SB   = 16;
  localparam int OVS  = 16;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       i_wr = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic [7:0] i_dvsr = 8'd4;
  logic [1:0] i_parity_mode = 2'd0;
  logic       o_tx, o_full, o_empty, o_busy, o_done_tick, o_overflow;
  logic [2:0] o_level;

  uart_tx_channel_gen2 dut (
    .clk(clk), .reset(reset), .i_wr(i_wr), .i_data(i_data), .i_dvsr(i_dvsr),
    .i_parity_mode(i_parity_mode), .o_tx(o_tx), .o_full(o_full), .o_empty(o_empty),
    .o_level(o_level), .o_busy(o_busy), .o_done_tick(o_done_tick), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; logic has_par; logic par; } frame_t;
  typedef struct { logic [1:0] mode; logic [7:0] data; logic par_used; logic par; } vec_t;

  frame_t q[$];
  vec_t   vecs[5];
  int     checks = 0;
  int     errors = 0;
  int     pushed = 0;
  int     done_frames = 0;
  int     cur_d = 4;
  bit     ignore_frames = 1'b0;
  logic   mon_prev = 1'b1;
  int     exp_lvl[6]  = '{1, 1, 2, 3, 4, 4};
  int     exp_full[6] = '{0, 0, 0, 0, 1, 1};
  int     exp_ovf[6]  = '{0, 0, 0, 0, 0, 1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Decode one frame; called at the first negedge showing the start bit.
  task automatic run_frame();
    frame_t f;
    int p, d, cur, tgt, nb;
    bit got;
    f = q.pop_front();
    d = cur_d;
    p = OVS * d;
    cur = 0;
    tgt = p / 2;
    repeat (tgt - cur) @(negedge clk);
    cur = tgt;
    chk("start_bit", o_tx, 0);
    chk("busy_in_frame", o_busy, 1);
    nb = f.has_par ? DBIT + 1 : DBIT;
    for (int k = 0; k < nb; k++) begin
      tgt = p - d / 2 + p / 2 + k * p;
      repeat (tgt - cur) @(negedge clk);
      cur = tgt;
      if (k < DBIT) chk($sformatf("data_bit%0d", k), o_tx, f.data[k]);
      else          chk("parity_bit", o_tx, f.par);
    end
    tgt = p - d / 2 + nb * p + (SB * d) / 2;
    repeat (tgt - cur) @(negedge clk);
    chk("stop_bit", o_tx, 1);
    chk("done_not_early", o_done_tick, 0);
    got = 1'b0;
    for (int i = 0; i < SB * d + p && !got; i++) begin
      @(negedge clk);
      if (o_done_tick) got = 1'b1;
    end
    chk("done_tick_seen", got, 1);
    done_frames++;
    @(negedge clk);
    chk("done_tick_width", o_done_tick, 0);
  endtask

  // Monitor: detects frame starts and checks them against the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && mon_prev && !o_tx && !ignore_frames) begin
        chk("frame_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          run_frame();
          while (q.size() > 0) begin
            @(negedge clk);
            chk("b2b_one_idle_clock", o_tx, 0);
            if (o_tx !== 1'b0) break;
            run_frame();
          end
        end
      end
      mon_prev = o_tx;
    end
  end

  task automatic send(input logic [7:0] d, input logic hp, input logic pb);
    @(negedge clk);
    i_wr = 1'b1;
    i_data = d;
    q.push_back('{d, hp, pb});
    pushed++;
    @(negedge clk);
    i_wr = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20000 && done_frames != pushed; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("frames_complete", done_frames, pushed);
    chk("idle_not_busy", o_busy, 0);
  endtask

  task automatic check_fifo(input int j);
    chk($sformatf("fifo_level_w%0d", j), o_level, exp_lvl[j]);
    chk($sformatf("fifo_full_w%0d", j), o_full, exp_full[j]);
    chk($sformatf("fifo_ovf_w%0d", j), o_overflow, exp_ovf[j]);
    chk($sformatf("fifo_empty_w%0d", j), o_empty, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'd1, 8'h07, 1'b1, 1'b1};
    vecs[1] = '{2'd2, 8'h07, 1'b1, 1'b0};
    vecs[2] = '{2'd1, 8'hA5, 1'b1, 1'b0};
    vecs[3] = '{2'd2, 8'hA5, 1'b1, 1'b1};
    vecs[4] = '{2'd3, 8'h3C, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_tx", o_tx, 1);
    chk("rst_empty", o_empty, 1);
    chk("rst_full", o_full, 0);
    chk("rst_level", o_level, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done_tick, 0);
    chk("rst_overflow", o_overflow, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // 8N1 frame of 0xA5 at divisor 4
    cur_d = 4; i_dvsr = 8'd4; i_parity_mode = 2'd0;
    send(8'hA5, 1'b0, 1'b0);
    wait_idle();

    // Parity modes
    for (int v = 0; v < 5; v++) begin
      i_parity_mode = vecs[v].mode;
      send(vecs[v].data, PAR_EN && vecs[v].par_used, vecs[v].par);
      wait_idle();
    end
    i_parity_mode = 2'd0;

    // Divisors 1 and 0 give a tick every clock
    cur_d = 1; i_dvsr = 8'd1;
    send(8'h96, 1'b0, 1'b0);
    wait_idle();
    i_dvsr = 8'd0;
    send(8'h69, 1'b0, 1'b0);
    wait_idle();

    // Six writes on consecutive clocks into a depth-4 FIFO
    cur_d = 4; i_dvsr = 8'd4;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k > 0) check_fifo(k - 1);
      i_wr = 1'b1;
      i_data = 8'(8'h30 + k);
      if (k < 5) begin
        q.push_back('{8'(8'h30 + k), 1'b0, 1'b0});
        pushed++;
      end
    end
    @(negedge clk);
    i_wr = 1'b0;
    check_fifo(5);
    @(negedge clk);
    chk("overflow_one_pulse", o_overflow, 0);
    chk("level_peak_hold", o_level, 4);
    wait_idle();
    chk("drained_level", o_level, 0);
    chk("drained_empty", o_empty, 1);

    // Reset in the middle of a data bit that is driving the line low
    ignore_frames = 1'b1;
    @(negedge clk); i_wr = 1'b1; i_data = 8'h5A;
    @(negedge clk); i_data = 8'h11;
    @(negedge clk); i_wr = 1'b0;
    repeat (98) @(negedge clk);
    chk("pre_reset_tx_low", o_tx, 0);
    chk("pre_reset_busy", o_busy, 1);
    chk("pre_reset_level", o_level, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_tx_high", o_tx, 1);
    chk("abort_empty", o_empty, 1);
    chk("abort_busy", o_busy, 0);
    chk("abort_level", o_level, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    ignore_frames = 1'b0;
    send(8'hC3, 1'b0, 1'b0);
    wait_idle();

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
